// File: rtl/angle_step_gen_360.sv
// Degree-domain phase accumulator feeding a 360-entry cos/sin table: bursts of N angles or a continuous stream.
// Optional build macro ANGLE_GEN_PHASE_OFFSET_EN adds a per-cycle output phase offset (offset_i).
module angle_step_gen_360 #(
  parameter int FRAC_BITS = 8,
  parameter int CNT_W     = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
`ifdef ANGLE_GEN_PHASE_OFFSET_EN
  input  logic [8:0]             offset_i,
`endif
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [9+FRAC_BITS-1:0] step_i,
  input  logic [8:0]             phase_i,
  input  logic [CNT_W-1:0]       count_i,
  output logic [8:0]             angle_o,
  output logic                   valid_o,
  output logic                   wrap_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int ACC_W = 9 + FRAC_BITS;
  localparam logic [ACC_W:0] MOD = (ACC_W+1)'(360) << FRAC_BITS;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               acc_wrap_q, acc_wrap_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   step_q, step_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [8:0]         angle_d;
  logic               valid_d, wrap_d, done_d, err_d;

  logic               start_bad;
  logic [ACC_W-1:0]   acc_src, step_src, acc_next;
  logic [ACC_W:0]     sum;
  logic               sum_wrap;
  logic [8:0]         angle_raw, angle_val;
  logic               last_sample;

  assign start_bad = (step_i[ACC_W-1:FRAC_BITS] >= 9'd360) || (phase_i >= 9'd360);

  // The accumulator runs one step ahead of angle_o: on accept the start phase is
  // emitted directly and acc already holds phase + step.
  assign acc_src  = (state_q == IDLE) ? {phase_i, {FRAC_BITS{1'b0}}} : acc_q;
  assign step_src = (state_q == IDLE) ? step_i : step_q;
  assign sum      = {1'b0, acc_src} + {1'b0, step_src};
  assign sum_wrap = (sum >= MOD);
  assign acc_next = sum_wrap ? ACC_W'(sum - MOD) : sum[ACC_W-1:0];

  assign angle_raw = acc_src[ACC_W-1:FRAC_BITS];

`ifdef ANGLE_GEN_PHASE_OFFSET_EN
  logic [8:0] off_red;
  logic [9:0] angle_sum;
  assign off_red   = (offset_i >= 9'd360) ? 9'(offset_i - 9'd360) : offset_i;
  assign angle_sum = {1'b0, angle_raw} + {1'b0, off_red};
  assign angle_val = (angle_sum >= 10'd360) ? 9'(angle_sum - 10'd360) : angle_sum[8:0];
`else
  assign angle_val = angle_raw;
`endif

  assign last_sample = (count_q != '0) && (cnt_q == count_q);
  assign busy_o      = (state_q == RUN);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    acc_wrap_d = acc_wrap_q;
    cnt_d      = cnt_q;
    step_d     = step_q;
    count_d    = count_q;
    angle_d    = angle_o;
    valid_d    = 1'b0;
    wrap_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (start_bad) begin
            err_d = 1'b1;
          end else begin
            state_d    = RUN;
            step_d     = step_i;
            count_d    = count_i;
            acc_d      = acc_next;
            acc_wrap_d = sum_wrap;
            cnt_d      = CNT_W'(1);
            angle_d    = angle_val;
            valid_d    = 1'b1;
          end
        end
      end
      RUN: begin
        // stop and count-reached share one exit path, so they yield a single done pulse
        if (stop_i || last_sample) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          angle_d    = angle_val;
          valid_d    = 1'b1;
          wrap_d     = acc_wrap_q;
          acc_d      = acc_next;
          acc_wrap_d = sum_wrap;
          cnt_d      = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      acc_wrap_q <= 1'b0;
      cnt_q      <= '0;
      step_q     <= '0;
      count_q    <= '0;
      angle_o    <= '0;
      valid_o    <= 1'b0;
      wrap_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      acc_wrap_q <= acc_wrap_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      count_q    <= count_d;
      angle_o    <= angle_d;
      valid_o    <= valid_d;
      wrap_o     <= wrap_d;
      done_o     <= done_d;
      err_o      <= err_d;
    end
  end

endmodule
